mac_spike_driver: RTL and testbench
===================================

# mac_spike_driver

Upstream driver for the `mac` block. It collects per-timestep spike events from the router side into the 4-bit `spike_in` vector and holds a double-buffered IEEE-754 weight bank that drives `weights_in`. At each timestep boundary it issues the vector and the weights to `mac`, waits a fixed latency, captures `result`, and returns it over a valid/ready handshake. It sits between the NoC ingress and one `mac` instance.

## Interface
- `N_INPUTS`, 4: synapse lanes; width of `spike_in`.
- `WORD`, 32: IEEE-754 single-precision word width.
- `MAC_LATENCY`, 1: cycles `spike_in`/`weights_in` are held stable before `mac_result` is sampled; must be ≥1.
- `CLK`  in  1: single clock, rising edge.
- `RESET`  in  1: synchronous, active-low reset.
- `ev_valid`  in  1: spike event offered.
- `ev_index`  in  2: source lane of the event, 0..N_INPUTS-1.
- `ev_ready`  out  1: event accepted when `ev_valid & ev_ready`.
- `ts_end`  in  1: single-cycle end-of-timestep pulse.
- `w_wr_en`  in  1: write to the shadow weight bank.
- `w_wr_addr`  in  2: lane to write.
- `w_wr_data`  in  32: IEEE-754 weight.
- `spike_in`  out  4: to `mac`; bit i = lane i fired.
- `weights_in`  out  128: to `mac`; lane i = bits [32i+31:32i].
- `mac_result`  in  32: `result` from `mac`.
- `res_valid`  out  1: captured result available.
- `res_data`  out  32: captured result.
- `res_ready`  in  1: consumer accepts the result.
- `ts_drop`  out  1: one-cycle pulse when a `ts_end` is ignored.

## Operation
- States: COLLECT, WAIT, HOLD. Reset state is COLLECT.
- `ev_ready` is 1 in every state. An accepted event ORs bit `ev_index` into the `pending` vector. Duplicate events within one timestep have no further effect.
- Weight writes go to the shadow bank in any state. The active bank drives `weights_in`. The shadow bank is copied to the active bank only on issue.
- COLLECT with `ts_end`=1 (issue):
  - `spike_in` ← `pending`, plus the bit of any event accepted the same cycle.
  - Active bank ← shadow bank, including any weight write made the same cycle.
  - `pending` ← 0.
  - `cnt` ← MAC_LATENCY; next state WAIT.
- Issue with an empty vector is legal. The result is still captured and returned.
- WAIT:
  - `cnt` decrements each cycle.
  - On the cycle where `cnt`=1: `res_data` ← `mac_result`, `res_valid` ← 1, next state HOLD.
  - `spike_in` and `weights_in` are held constant throughout WAIT.
- HOLD: `res_valid` stays 1 and `res_data` is stable until `res_ready`=1. On the handshake, `res_valid` ← 0, `spike_in` ← 0, and the next state is COLLECT.
- `ts_end` in WAIT or HOLD is ignored and `ts_drop` pulses the next cycle. Events accepted in those states stay in `pending` for the next timestep.
- Out-of-range `ev_index` or `w_wr_addr` (not possible at N_INPUTS=4) is ignored.
- No arithmetic is performed on weights. Words pass through bit-exact.

## Timing
- Reset (RESET=0 at an edge) sets:
  - `spike_in`=0, `weights_in`=0, `res_valid`=0, `res_data`=0, `ts_drop`=0.
  - Both weight banks = 0, `pending`=0, `cnt`=0, state COLLECT.
  - `ev_ready` is 1 in the cycle after reset.
- Reset mid-operation abandons the timestep. No `res_valid` is produced and all pending events are lost.
- With `ts_end` sampled at edge T:
  - `spike_in` and `weights_in` update at edge T+1.
  - `res_valid` rises at edge T+1+MAC_LATENCY.
  - `mac_result` is sampled after being driven by stable inputs for MAC_LATENCY cycles.
- `res_ready` already high when `res_valid` rises: the handshake completes on the next edge and COLLECT resumes.
- Back-to-back throughput: one timestep per MAC_LATENCY+2 cycles minimum.
- All outputs are registered. There are no combinational paths from inputs to outputs except `ev_ready`, which is constant 1.

## Test plan
- Reset, then load weights 0x3DCCCCCD, 0x40000000, 0x3F99999A, 0x40400000 into lanes 0..3. Send events on lanes 1 and 3, then `ts_end` → `spike_in`=4'b1010, and `weights_in` equals the four words with lane 0 in the LSBs. With a stub `mac` returning 0x40A00000 (5.0), `res_data`=0x40A00000 with `res_valid` exactly MAC_LATENCY+1 cycles after `ts_end`.
- Lane 0 event in the same cycle as `ts_end`, plus a duplicate lane 0 event earlier → `spike_in`=4'b0001.
- Weight write to lane 2 during WAIT → `weights_in` unchanged until the next issue, which then carries the new word.
- `ts_end` during HOLD with `res_ready`=0 for 5 cycles → `ts_drop` pulses once. `res_data` is stable. Events on lane 2 sent during HOLD appear in the next `spike_in`=4'b0100.
- RESET=0 asserted during WAIT with MAC_LATENCY=3 → no `res_valid`, and all outputs are 0 on the next cycle. A following `ts_end` issues `spike_in`=0 and `weights_in`=0.
- `ts_end` with no events → `spike_in`=0, and a result is still returned and handshaken.

Source files
------------

// File: rtl/mac_spike_driver_if.sv
// Bus bundle between the NoC-side environment, the spike driver and its mac instance.
// The driver itself attaches through the slave modport.
interface mac_spike_driver_if #(
  parameter int unsigned N_INPUTS = 4,
  parameter int unsigned WORD     = 32
);
  localparam int unsigned IDX_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

  logic                       ev_valid;
  logic [IDX_W-1:0]           ev_index;
  logic                       ev_ready;
  logic                       ts_end;
  logic                       w_wr_en;
  logic [IDX_W-1:0]           w_wr_addr;
  logic [WORD-1:0]            w_wr_data;
  logic [N_INPUTS-1:0]        spike_in;
  logic [N_INPUTS*WORD-1:0]   weights_in;
  logic [WORD-1:0]            mac_result;
  logic                       res_valid;
  logic [WORD-1:0]            res_data;
  logic                       res_ready;
  logic                       ts_drop;

  modport master (
    output ev_valid, ev_index, ts_end, w_wr_en, w_wr_addr, w_wr_data,
           mac_result, res_ready,
    input  ev_ready, spike_in, weights_in, res_valid, res_data, ts_drop
  );

  modport slave (
    input  ev_valid, ev_index, ts_end, w_wr_en, w_wr_addr, w_wr_data,
           mac_result, res_ready,
    output ev_ready, spike_in, weights_in, res_valid, res_data, ts_drop
  );
endinterface

// File: rtl/mac_spike_driver.sv
// Collects per-timestep spike events, double-buffers the weight bank, issues both to
// the mac at each timestep boundary and returns the captured result over valid/ready.
module mac_spike_driver #(
  parameter int unsigned N_INPUTS    = 4,
  parameter int unsigned WORD        = 32,
  parameter int unsigned MAC_LATENCY = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  mac_spike_driver_if.slave bus
);
  localparam int unsigned IDX_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam int unsigned CNT_W = $clog2(MAC_LATENCY + 1);

  typedef enum logic [1:0] {COLLECT, WAIT, HOLD} state_t;

  state_t                         state;
  logic [CNT_W-1:0]               cnt;
  logic [N_INPUTS-1:0]            pending;
  logic [N_INPUTS-1:0]            pending_next;
  logic [N_INPUTS-1:0]            spike;
  logic [N_INPUTS-1:0][WORD-1:0]  shadow;
  logic [N_INPUTS-1:0][WORD-1:0]  shadow_next;
  logic [N_INPUTS-1:0][WORD-1:0]  active;
  logic                           res_valid_q;
  logic [WORD-1:0]                res_data_q;
  logic                           ts_drop_q;

  // Same-cycle event and weight write are folded in here so an issue picks them up;
  // indices that match no lane simply fall through.
  always_comb begin
    pending_next = pending;
    shadow_next  = shadow;
    for (int unsigned i = 0; i < N_INPUTS; i++) begin
      if (bus.ev_valid && bus.ev_index == IDX_W'(i))
        pending_next[i] = 1'b1;
      if (bus.w_wr_en && bus.w_wr_addr == IDX_W'(i))
        shadow_next[i] = bus.w_wr_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state       <= COLLECT;
      cnt         <= '0;
      pending     <= '0;
      spike       <= '0;
      shadow      <= '0;
      active      <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      ts_drop_q   <= 1'b0;
    end else begin
      ts_drop_q <= 1'b0;
      pending   <= pending_next;
      shadow    <= shadow_next;
      case (state)
        COLLECT: begin
          if (bus.ts_end) begin
            spike   <= pending_next;
            active  <= shadow_next;
            pending <= '0;
            cnt     <= CNT_W'(MAC_LATENCY);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (bus.ts_end) ts_drop_q <= 1'b1;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            res_data_q  <= bus.mac_result;
            res_valid_q <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (bus.ts_end) ts_drop_q <= 1'b1;
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            spike       <= '0;
            state       <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  assign bus.ev_ready   = 1'b1;
  assign bus.spike_in   = spike;
  assign bus.weights_in = active;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;
  assign bus.ts_drop    = ts_drop_q;
endmodule

// File: tb/tb_mac_spike_driver.sv
// Directed bench for mac_spike_driver with a combinational stub standing in for mac.
module tb_mac_spike_driver;
  localparam int unsigned LAT = 3;

  localparam logic [31:0] W0 = 32'h3DCC_CCCD;
  localparam logic [31:0] W1 = 32'h4000_0000;
  localparam logic [31:0] W2 = 32'h3F99_999A;
  localparam logic [31:0] W3 = 32'h4040_0000;
  localparam logic [31:0] W2_NEW = 32'hC049_0FDB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  mac_spike_driver_if #(.N_INPUTS(4), .WORD(32)) bus ();

  mac_spike_driver #(.N_INPUTS(4), .WORD(32), .MAC_LATENCY(LAT)) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Stub mac: 5.0 for vector 1010, low nibble tagged by the vector otherwise.
  assign bus.mac_result = 32'h40A0_0000 ^ {28'h0, bus.spike_in ^ 4'b1010};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ev(input logic [1:0] idx);
    bus.ev_valid = 1'b1;
    bus.ev_index = idx;
  endtask

  task automatic wr(input logic [1:0] addr, input logic [31:0] data);
    bus.w_wr_en   = 1'b1;
    bus.w_wr_addr = addr;
    bus.w_wr_data = data;
  endtask

  task automatic idle();
    bus.ev_valid = 1'b0;
    bus.w_wr_en  = 1'b0;
    bus.ts_end   = 1'b0;
  endtask

  task automatic start_ts();
    bus.ts_end = 1'b1;
    tick();
    idle();
  endtask

  // Bounded wait; returned count includes cycles already spent since ts_end.
  task automatic wait_valid(input int start, output int lat);
    lat = start;
    while (bus.res_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic handshake();
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic seen;
    logic [127:0] w_all;
    w_all = {W3, W2, W1, W0};

    bus.ev_valid = 1'b0; bus.ev_index = '0; bus.ts_end = 1'b0;
    bus.w_wr_en = 1'b0; bus.w_wr_addr = '0; bus.w_wr_data = '0;
    bus.res_ready = 1'b0;

    tick(); tick();
    chk("rst_spike", 128'(bus.spike_in), 128'(0));
    chk("rst_weights", bus.weights_in, 128'(0));
    chk("rst_valid", 128'(bus.res_valid), 128'(0));
    chk("rst_data", 128'(bus.res_data), 128'(0));
    chk("rst_drop", 128'(bus.ts_drop), 128'(0));
    rst_n = 1'b1;
    tick();
    chk("ev_ready", 128'(bus.ev_ready), 128'(1));

    // Load weights, events on lanes 1 and 3, then issue.
    wr(2'd0, W0); tick();
    wr(2'd1, W1); ev(2'd1); tick(); idle();
    wr(2'd2, W2); tick();
    wr(2'd3, W3); ev(2'd3); tick(); idle();
    chk("shadow_not_active", bus.weights_in, 128'(0));
    start_ts();
    chk("t1_spike", 128'(bus.spike_in), 128'(4'b1010));
    chk("t1_weights", bus.weights_in, w_all);
    chk("t1_no_early_valid", 128'(bus.res_valid), 128'(0));
    wait_valid(1, lat);
    chk("t1_latency", 128'(lat), 128'(LAT + 1));
    chk("t1_data", 128'(bus.res_data), 128'(32'h40A0_0000));
    chk("t1_spike_held", 128'(bus.spike_in), 128'(4'b1010));
    handshake();
    chk("t1_valid_clr", 128'(bus.res_valid), 128'(0));
    chk("t1_spike_clr", 128'(bus.spike_in), 128'(0));

    // Duplicate lane 0 event, second one coincident with ts_end; ready held high.
    bus.res_ready = 1'b1;
    ev(2'd0); tick();
    ev(2'd0); start_ts();
    chk("t2_spike", 128'(bus.spike_in), 128'(4'b0001));
    wait_valid(1, lat);
    chk("t2_latency", 128'(lat), 128'(LAT + 1));
    chk("t2_data", 128'(bus.res_data), 128'(32'h40A0_000B));
    tick();
    chk("t2_auto_hs", 128'(bus.res_valid), 128'(0));
    bus.res_ready = 1'b0;

    // Weight write during WAIT stays in the shadow bank.
    start_ts();
    wr(2'd2, W2_NEW); tick(); idle();
    chk("t3_weights_held", bus.weights_in, w_all);
    wait_valid(2, lat);
    chk("t3_weights_hold", bus.weights_in, w_all);
    handshake();

    // Empty issue carries the new lane 2 word and still returns a result.
    start_ts();
    chk("t6_spike_empty", 128'(bus.spike_in), 128'(0));
    chk("t3_weights_new", bus.weights_in, {W3, W2_NEW, W1, W0});
    wait_valid(1, lat);
    chk("t6_latency", 128'(lat), 128'(LAT + 1));
    chk("t6_data", 128'(bus.res_data), 128'(32'h40A0_000A));

    // ts_end during HOLD is dropped; lane 2 event kept for the next timestep.
    bus.ts_end = 1'b1; ev(2'd2); tick(); idle();
    chk("t4_drop_pulse", 128'(bus.ts_drop), 128'(1));
    tick();
    chk("t4_drop_single", 128'(bus.ts_drop), 128'(0));
    tick(); tick(); tick();
    chk("t4_valid_held", 128'(bus.res_valid), 128'(1));
    chk("t4_data_stable", 128'(bus.res_data), 128'(32'h40A0_000A));
    handshake();
    chk("t4_valid_clr", 128'(bus.res_valid), 128'(0));
    start_ts();
    chk("t4_spike_next", 128'(bus.spike_in), 128'(4'b0100));
    wait_valid(1, lat);
    chk("t4_data_next", 128'(bus.res_data), 128'(32'h40A0_000E));
    handshake();

    // Reset in the middle of WAIT abandons the timestep.
    wr(2'd0, 32'h1234_5678); tick(); idle();
    ev(2'd1); start_ts();
    ev(2'd3); tick(); idle();
    bus.ts_end = 1'b1;
    rst_n = 1'b0;
    tick();
    bus.ts_end = 1'b0;
    chk("t5_spike", 128'(bus.spike_in), 128'(0));
    chk("t5_weights", bus.weights_in, 128'(0));
    chk("t5_valid", 128'(bus.res_valid), 128'(0));
    chk("t5_data", 128'(bus.res_data), 128'(0));
    chk("t5_drop", 128'(bus.ts_drop), 128'(0));
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen = seen | bus.res_valid;
    end
    chk("t5_no_valid", 128'(seen), 128'(0));
    start_ts();
    chk("t5_spike_after", 128'(bus.spike_in), 128'(0));
    chk("t5_weights_after", bus.weights_in, 128'(0));
    wait_valid(1, lat);
    chk("t5_latency", 128'(lat), 128'(LAT + 1));
    chk("t5_data_after", 128'(bus.res_data), 128'(32'h40A0_000A));
    handshake();
    chk("t5_valid_clr", 128'(bus.res_valid), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
